nav_cmd_sequencer: RTL and testbench



---
 rtl/nav_cmd_pkg.sv | 44 ++++
 rtl/json_cmd_rom.sv | 22 ++
 rtl/nav_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_nav_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_cmd_pkg.sv
// nav_cmd_pkg
// Shared types and constants for the navigation command sequencer:
//   cmd_e      - motor command encoding (STOP, FWD, LEFT, RIGHT)
//   state_e    - sequencer FSM states
//   FRAME_LEN  - bytes per JSON frame, including the trailing newline
//   FRAME_TABLE- constant frame text, one 24-byte frame per command
//   arbitrate  - fixed-priority pick among simultaneous request lines
package nav_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_FWD   = 2'd1,
    CMD_LEFT  = 2'd2,
    CMD_RIGHT = 2'd3
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int unsigned FRAME_LEN = 24;
  localparam logic [4:0]  LAST_IDX  = 5'(FRAME_LEN - 1);

  // Ascending byte range so element 0 is the first character of the literal.
  typedef logic [0:FRAME_LEN-1][7:0] frame_t;

  localparam frame_t FRAME_STOP  = "{\"T\":1,\"L\":0.0,\"R\":0.0}\n";
  localparam frame_t FRAME_FWD   = "{\"T\":1,\"L\":0.5,\"R\":0.5}\n";
  localparam frame_t FRAME_LEFT  = "{\"T\":1,\"L\":0.0,\"R\":0.5}\n";
  localparam frame_t FRAME_RIGHT = "{\"T\":1,\"L\":0.5,\"R\":0.0}\n";

  // Indexed by cmd_e: leftmost concatenation element lands at index 3.
  localparam frame_t [3:0] FRAME_TABLE = {FRAME_RIGHT, FRAME_LEFT, FRAME_FWD, FRAME_STOP};

  // STOP wins over everything so a safety stop is never masked by motion.
  function automatic cmd_e arbitrate(input logic [3:0] req);
    if (req[0]) return CMD_STOP;
    if (req[2]) return CMD_LEFT;
    if (req[3]) return CMD_RIGHT;
    return CMD_FWD;
  endfunction

endpackage

// File: rtl/json_cmd_rom.sv
// json_cmd_rom
// Combinational frame lookup.
//   cmd  in  cmd_e : which frame
//   idx  in  5     : byte position within the frame
//   data out 8     : frame byte (0x00 for positions past the frame end)
module json_cmd_rom
  import nav_cmd_pkg::*;
(
  input  cmd_e       cmd,
  input  logic [4:0] idx,
  output logic [7:0] data
);

  frame_t frame;

  always_comb begin
    frame = FRAME_TABLE[cmd];
    data  = 8'h00;
    if (idx < 5'(FRAME_LEN)) data = frame[idx];
  end

endmodule

// File: rtl/nav_cmd_sequencer.sv
// nav_cmd_sequencer
// Arbitrates motor-command requests and streams the selected JSON frame
// onto the uart_tx byte handshake, re-sending the last command as a
// keep-alive after REPEAT_CYCLES idle cycles (0 disables keep-alive).
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : allows new frames to start; a running frame always completes
//   cmd_req[3:0]: request lines indexed by cmd_e
//   tx_byte/tx_valid/tx_ready : byte stream towards uart_tx
//   busy        : high while a frame is being sent
//   frame_done  : one-cycle pulse after the last byte is accepted
//   cur_cmd     : command of the current or most recent frame
module nav_cmd_sequencer
  import nav_cmd_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] cmd_req,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] cur_cmd
);

  localparam bit          REP_EN  = (REPEAT_CYCLES != 0);
  localparam int          CNT_W   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REP_EN ? REPEAT_CYCLES - 1 : 0);

  state_e           state;
  logic [4:0]       idx;
  cmd_e             frame_cmd;
  cmd_e             last_cmd;
  logic             last_valid;
  logic             pend_valid;
  cmd_e             pend_cmd;
  logic [CNT_W-1:0] rep_cnt;

  logic       req_any;
  cmd_e       req_cmd;
  logic       accept;
  logic       last_byte;
  logic       start_pend;
  logic       start_req;
  logic       start_rep;
  logic       start;
  cmd_e       start_cmd;
  cmd_e       rom_cmd;
  logic [4:0] rom_idx;
  logic [7:0] rom_byte;

  assign req_any   = |cmd_req;
  assign req_cmd   = arbitrate(cmd_req);
  assign accept    = tx_valid && tx_ready;
  assign last_byte = accept && (idx == LAST_IDX);

  // A pending command is served first; with an empty slot a fresh request
  // bypasses the slot so it reaches the wire on the next cycle.
  assign start_pend = (state == ST_IDLE) && enable && pend_valid;
  assign start_req  = (state == ST_IDLE) && enable && !pend_valid && req_any;
  assign start_rep  = (state == ST_IDLE) && enable && !pend_valid && !req_any &&
                      REP_EN && last_valid && (rep_cnt == REP_MAX);
  assign start      = start_pend || start_req || start_rep;

  always_comb begin
    start_cmd = last_cmd;
    if (start_pend)     start_cmd = pend_cmd;
    else if (start_req) start_cmd = req_cmd;
  end

  // The ROM is addressed with the byte that will be presented next cycle.
  assign rom_cmd = (state == ST_IDLE) ? start_cmd : frame_cmd;
  assign rom_idx = (state == ST_IDLE) ? 5'd0 : idx + 5'd1;

  json_cmd_rom u_rom (
    .cmd  (rom_cmd),
    .idx  (rom_idx),
    .data (rom_byte)
  );

  // Pending slot: a request landing in the cycle the slot is consumed is
  // captured, and a held STOP can only be displaced by another STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_STOP;
    end else if (req_any && !start_req &&
                 (!pend_valid || start_pend || pend_cmd != CMD_STOP || req_cmd == CMD_STOP)) begin
      pend_valid <= 1'b1;
      pend_cmd   <= req_cmd;
    end else if (start_pend) begin
      pend_valid <= 1'b0;
    end
  end

  // Keep-alive counter: saturates at REP_MAX and only advances while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (last_byte || req_any || !enable) begin
      rep_cnt <= '0;
    end else if (state == ST_IDLE && rep_cnt != REP_MAX) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 5'd0;
      tx_byte    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cmd  <= CMD_STOP;
      last_cmd   <= CMD_STOP;
      last_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEND;
            idx       <= 5'd0;
            frame_cmd <= start_cmd;
            tx_byte   <= rom_byte;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state      <= ST_IDLE;
              idx        <= 5'd0;
              tx_byte    <= 8'h00;
              tx_valid   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              last_cmd   <= frame_cmd;
              last_valid <= 1'b1;
            end else begin
              idx     <= idx + 5'd1;
              tx_byte <= rom_byte;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cur_cmd = frame_cmd;

endmodule

// File: tb/tb_nav_cmd_sequencer.sv
// tb_nav_cmd_sequencer
// Directed and randomized checks of nav_cmd_sequencer against a frame-level
// model: expected frames are built as text from the command's wheel speeds,
// and the expected follow-up frame comes from the request/priority rules.
module tb_nav_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] cmd_req;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic [1:0] cur_cmd;

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  nav_cmd_sequencer #(.REPEAT_CYCLES(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cmd_req    (cmd_req),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .cur_cmd    (cur_cmd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Command codes: 0 STOP, 1 FWD, 2 LEFT, 3 RIGHT.
  function automatic string frame_text(input int c);
    string l;
    string r;
    if (c == 1 || c == 3) l = "0.5"; else l = "0.0";
    if (c == 1 || c == 2) r = "0.5"; else r = "0.0";
    return $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", l, r);
  endfunction

  // Priority STOP > LEFT > RIGHT > FWD; -1 means no request.
  function automatic int winner(input logic [3:0] r);
    if (r[0]) return 0;
    if (r[2]) return 2;
    if (r[3]) return 3;
    if (r[1]) return 1;
    return -1;
  endfunction

  // Called at a negedge. Collects nbytes accepted bytes, optionally with a
  // random tx_ready, and pulses req_a/req_b while byte at_a/at_b is shown.
  task automatic recv_frame(input bit rnd, input int nbytes,
                            input int at_a, input logic [3:0] req_a,
                            input int at_b, input logic [3:0] req_b);
    bit stall = 1'b0;
    bit done_a = 1'b0;
    bit done_b = 1'b0;
    logic [7:0] held = 8'h00;
    int cyc = 0;
    rx_q.delete();
    while (rx_q.size() < nbytes && cyc < 400) begin
      if (stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_byte", 32'(tx_byte), 32'(held));
      end
      stall = 1'b0;
      cmd_req = 4'b0000;
      if (tx_valid && !done_a && rx_q.size() == at_a) begin
        cmd_req = req_a;
        done_a = 1'b1;
      end
      if (tx_valid && !done_b && rx_q.size() == at_b) begin
        cmd_req = cmd_req | req_b;
        done_b = 1'b1;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid) begin
        if (tx_ready) rx_q.push_back(tx_byte);
        else begin
          stall = 1'b1;
          held = tx_byte;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cmd_req = 4'b0000;
    tx_ready = 1'b1;
    check("recv_count", 32'(rx_q.size()), 32'(nbytes));
  endtask

  task automatic check_frame(input string tag, input int c);
    string s;
    logic [7:0] got;
    s = frame_text(c);
    for (int i = 0; i < 24; i++) begin
      got = 8'hxx;
      if (i < rx_q.size()) got = rx_q[i];
      check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(s[i]));
    end
  endtask

  // Called at the negedge right after the last accept.
  task automatic check_end(input string tag, input int c);
    check($sformatf("%s_done", tag), 32'(frame_done), 32'd1);
    check($sformatf("%s_valid_low", tag), 32'(tx_valid), 32'd0);
    check($sformatf("%s_busy_low", tag), 32'(busy), 32'd0);
    check($sformatf("%s_cur_cmd", tag), 32'(cur_cmd), 32'(c));
  endtask

  initial begin
    int n;
    int s;
    int exp_c;
    logic [3:0] r0;
    logic [3:0] ra;
    logic [3:0] rb;
    int a;
    int b;

    rst_n = 1'b0;
    enable = 1'b1;
    cmd_req = 4'b0000;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_cur_cmd", 32'(cur_cmd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FWD frame with tx_ready held high; first byte one cycle after request.
    cmd_req = 4'b0010;
    @(negedge clk);
    cmd_req = 4'b0000;
    check("lat_valid", 32'(tx_valid), 32'd1);
    check("lat_byte", 32'(tx_byte), 32'h7B);
    check("lat_busy", 32'(busy), 32'd1);
    recv_frame(1'b0, 24, -1, 4'b0000, -1, 4'b0000);
    check_frame("fwd", 1);
    check("fwd_b0", 32'(rx_q[0]), 32'h7B);
    check("fwd_b1", 32'(rx_q[1]), 32'h22);
    check("fwd_b2", 32'(rx_q[2]), 32'h54);
    check("fwd_b11", 32'(rx_q[11]), 32'h30);
    check("fwd_b12", 32'(rx_q[12]), 32'h2E);
    check("fwd_b13", 32'(rx_q[13]), 32'h35);
    check("fwd_b23", 32'(rx_q[23]), 32'h0A);
    check_end("fwd", 1);
    @(negedge clk);
    check("done_single", 32'(frame_done), 32'd0);

    // Simultaneous STOP, LEFT, RIGHT: STOP wins.
    cmd_req = 4'b1101;
    @(negedge clk);
    cmd_req = 4'b0000;
    recv_frame(1'b0, 24, -1, 4'b0000, -1, 4'b0000);
    check_frame("prio", winner(4'b1101));
    check("prio_b11", 32'(rx_q[11]), 32'h30);
    check_end("prio", 0);
    @(negedge clk);

    // FWD frame, STOP at byte 5, LEFT at byte 10: STOP follows, LEFT dropped.
    cmd_req = 4'b0010;
    @(negedge clk);
    cmd_req = 4'b0000;
    recv_frame(1'b0, 24, 5, 4'b0001, 10, 4'b0100);
    check_frame("prefwd", 1);
    check_end("prefwd", 1);
    @(negedge clk);
    check("gap_valid", 32'(tx_valid), 32'd1);
    check("gap_byte", 32'(tx_byte), 32'h7B);
    recv_frame(1'b0, 24, -1, 4'b0000, -1, 4'b0000);
    check_frame("stopq", 0);
    check_end("stopq", 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    check("no_left", 32'(n), 32'd0);

    // Randomized requests and back-pressure.
    r0 = 4'($urandom_range(1, 15));
    cmd_req = r0;
    @(negedge clk);
    cmd_req = 4'b0000;
    exp_c = winner(r0);
    for (int k = 0; k < 6; k++) begin
      ra = (k < 5) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rb = (k < 5) ? 4'($urandom_range(0, 15)) : 4'b0000;
      a = int'($urandom_range(1, 10));
      b = int'($urandom_range(11, 22));
      recv_frame(1'b1, 24, a, ra, b, rb);
      check_frame($sformatf("rand%0d", k), exp_c);
      check_end($sformatf("rand%0d", k), exp_c);
      s = -1;
      if (ra != 4'b0000) s = winner(ra);
      if (rb != 4'b0000 && (s != 0 || winner(rb) == 0)) s = winner(rb);
      if (s >= 0) begin
        @(negedge clk);
        check($sformatf("rand%0d_next", k), 32'(tx_valid), 32'd1);
        exp_c = s;
      end else if (k < 5) begin
        r0 = 4'($urandom_range(1, 15));
        cmd_req = r0;
        @(negedge clk);
        cmd_req = 4'b0000;
        exp_c = winner(r0);
      end
    end

    // Keep-alive: resend 100 cycles after each frame_done, stop when disabled.
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!tx_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("ka%0d_gap", k), 32'(n), 32'd100);
      if (k == 1) enable = 1'b0;
      recv_frame(1'b0, 24, -1, 4'b0000, -1, 4'b0000);
      check_frame($sformatf("ka%0d", k), exp_c);
      check_end($sformatf("ka%0d", k), exp_c);
    end
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    check("ka_disabled", 32'(n), 32'd0);

    // Reset in the middle of a frame.
    enable = 1'b1;
    cmd_req = 4'b0010;
    @(negedge clk);
    cmd_req = 4'b0000;
    recv_frame(1'b0, 12, -1, 4'b0000, -1, 4'b0000);
    check("mid_valid", 32'(tx_valid), 32'd1);
    check("mid_byte12", 32'(tx_byte), 32'h2E);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_byte", 32'(tx_byte), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_cur_cmd", 32'(cur_cmd), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    check("post_rst_quiet", 32'(n), 32'd0);
    cmd_req = 4'b1000;
    @(negedge clk);
    cmd_req = 4'b0000;
    recv_frame(1'b0, 24, -1, 4'b0000, -1, 4'b0000);
    check_frame("right", 3);
    check_end("right", 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
